// File: rtl/controlador_arranque_rv32i_pkg.sv
// rv32i_pkg
// Shared definitions for the rv32i boot-and-run sequencer.
//   estado_t   : 2-bit sequencer state, also driven out on the estado port
//   OPC_ECALL  : ECALL encoding, stops execution
//   OPC_EBREAK : EBREAK encoding, stops execution
//   es_trampa  : true when a fetched word is one of the two stop instructions
package rv32i_pkg;

  typedef enum logic [1:0] {
    CARGA    = 2'b00,
    ARRANQUE = 2'b01,
    EJECUTA  = 2'b10,
    DETENIDO = 2'b11
  } estado_t;

  localparam logic [31:0] OPC_ECALL  = 32'h0000_0073;
  localparam logic [31:0] OPC_EBREAK = 32'h0010_0073;

  function automatic logic es_trampa(input logic [31:0] instr);
    return (instr == OPC_ECALL) || (instr == OPC_EBREAK);
  endfunction

endpackage

// File: rtl/controlador_arranque_rv32i_if.sv
// controlador_arranque_rv32i_if
// Program-load bus of the boot sequencer: the byte stream coming in and the
// instruction-memory write port going out.
//   byte_dato/byte_valido/byte_listo : byte stream, valid/ready handshake
//   fin_carga                        : one-cycle end-of-stream pulse
//   imem_we/imem_dir/imem_dato       : one-cycle word write into instruction memory
// The master modport is the host/memory side, the slave modport the sequencer.
interface controlador_arranque_rv32i_if #(
  parameter int ADDR_W = 8
);

  logic [7:0]        byte_dato;
  logic              byte_valido;
  logic              byte_listo;
  logic              fin_carga;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_dir;
  logic [31:0]       imem_dato;

  modport master (
    output byte_dato, byte_valido, fin_carga,
    input  byte_listo, imem_we, imem_dir, imem_dato
  );

  modport slave (
    input  byte_dato, byte_valido, fin_carga,
    output byte_listo, imem_we, imem_dir, imem_dato
  );

endinterface

// File: rtl/controlador_arranque_rv32i_empaquetador_bytes.sv
// empaquetador_bytes
// Packs a little-endian byte stream into 32-bit words and emits one
// registered write strobe per word.
//   clk_RV, reset        : clock, synchronous active-high reset
//   habilitado           : packing allowed (sequencer is loading)
//   byte_dato/valido     : incoming byte; byte_listo is the ready side
//   vaciar               : end of stream; a partial word is zero-padded and written
//   escribe              : a word write is being registered on this edge
//   palabra_valida/dir/dato : registered write strobe, word address and word
module empaquetador_bytes #(
  parameter int ADDR_W         = 8,
  parameter int N_PALABRAS_MAX = 256
) (
  input  logic              clk_RV,
  input  logic              reset,
  input  logic              habilitado,
  input  logic [7:0]        byte_dato,
  input  logic              byte_valido,
  output logic              byte_listo,
  input  logic              vaciar,
  output logic              escribe,
  output logic              palabra_valida,
  output logic [ADDR_W-1:0] palabra_dir,
  output logic [31:0]       palabra_dato
);

  logic [1:0]    cuenta;
  logic [31:0]   acumulado;
  logic [ADDR_W:0] indice;
  logic          lleno;
  logic          acepta;
  logic [31:0]   palabra_sig;

  // indice is one bit wider than the address so it can reach N_PALABRAS_MAX
  assign lleno      = (indice == (ADDR_W+1)'(N_PALABRAS_MAX));
  assign byte_listo = habilitado && !lleno;
  assign acepta     = byte_valido && byte_listo;

  // acumulado keeps unfilled upper bytes at zero, which gives the padding for free
  always_comb begin
    palabra_sig = acumulado;
    if (acepta) begin
      palabra_sig = acumulado | ({24'd0, byte_dato} << {cuenta, 3'b000});
    end
  end

  // A byte arriving with vaciar is folded into the flushed word; a flush with
  // no bytes pending produces no write
  assign escribe = acepta ? ((cuenta == 2'd3) || vaciar)
                          : (vaciar && habilitado && (cuenta != 2'd0) && !lleno);

  always_ff @(posedge clk_RV) begin
    if (reset) begin
      cuenta         <= 2'd0;
      acumulado      <= 32'd0;
      indice         <= '0;
      palabra_valida <= 1'b0;
      palabra_dir    <= '0;
      palabra_dato   <= 32'd0;
    end else begin
      palabra_valida <= escribe;
      if (escribe) begin
        palabra_dir  <= indice[ADDR_W-1:0];
        palabra_dato <= palabra_sig;
        indice       <= indice + (ADDR_W+1)'(1);
        cuenta       <= 2'd0;
        acumulado    <= 32'd0;
      end else if (acepta) begin
        acumulado <= palabra_sig;
        cuenta    <= cuenta + 2'd1;
      end
    end
  end

endmodule

// File: rtl/controlador_arranque_rv32i.sv
// controlador_arranque_rv32i
// Boot-and-run sequencer for the single-cycle rv32i core: loads the program
// into instruction memory with the core held in reset, releases it for
// execution, counts cycles and stops on ECALL/EBREAK or a cycle timeout.
//   clk_RV, reset        : clock, synchronous active-high reset
//   bus                  : byte stream in / instruction-memory writes out
//   instruccion          : word the core is currently fetching
//   cpu_reset, cpu_habilitar : core reset and clock enable
//   estado               : CARGA / ARRANQUE / EJECUTA / DETENIDO
//   ciclos               : executed-cycle count (saturating)
//   detenido, timeout    : stopped flag, and sticky "stopped by cycle limit"
// N_PALABRAS_MAX must not exceed 2**ADDR_W; CICLOS_ARRANQUE must be at least 1.
module controlador_arranque_rv32i
  import rv32i_pkg::*;
#(
  parameter int ADDR_W          = 8,
  parameter int N_PALABRAS_MAX  = 256,
  parameter int CICLOS_ARRANQUE = 2,
  parameter int MAX_CICLOS      = 200
) (
  input  logic                        clk_RV,
  input  logic                        reset,
  controlador_arranque_rv32i_if.slave bus,
  input  logic [31:0]                 instruccion,
  output logic                        cpu_reset,
  output logic                        cpu_habilitar,
  output logic [1:0]                  estado,
  output logic [31:0]                 ciclos,
  output logic                        detenido,
  output logic                        timeout
);

  estado_t     estado_q, estado_sig;
  logic        cerrando;
  logic [31:0] contador_arranque;
  logic        habilitado;
  logic        vaciar;
  logic        escribe;
  logic        trampa;
  logic        limite;
  logic        cpu_reset_sig, cpu_habilitar_sig, detenido_sig;

  // cerrando marks the one cycle in which the final word write is on the bus;
  // loading is closed then, and ARRANQUE follows on the next edge
  assign habilitado = (estado_q == CARGA) && !cerrando;
  assign vaciar     = habilitado && bus.fin_carga;
  assign trampa     = es_trampa(instruccion);
  assign limite     = (ciclos == 32'(MAX_CICLOS - 1));
  assign estado     = estado_q;

  empaquetador_bytes #(
    .ADDR_W         (ADDR_W),
    .N_PALABRAS_MAX (N_PALABRAS_MAX)
  ) u_empaquetador (
    .clk_RV         (clk_RV),
    .reset          (reset),
    .habilitado     (habilitado),
    .byte_dato      (bus.byte_dato),
    .byte_valido    (bus.byte_valido),
    .byte_listo     (bus.byte_listo),
    .vaciar         (vaciar),
    .escribe        (escribe),
    .palabra_valida (bus.imem_we),
    .palabra_dir    (bus.imem_dir),
    .palabra_dato   (bus.imem_dato)
  );

  // State register together with the registered core controls
  always_ff @(posedge clk_RV) begin
    if (reset) begin
      estado_q      <= CARGA;
      cerrando      <= 1'b0;
      cpu_reset     <= 1'b1;
      cpu_habilitar <= 1'b0;
      detenido      <= 1'b0;
    end else begin
      estado_q      <= estado_sig;
      cerrando      <= vaciar && escribe;
      cpu_reset     <= cpu_reset_sig;
      cpu_habilitar <= cpu_habilitar_sig;
      detenido      <= detenido_sig;
    end
  end

  // Next-state logic; trap and cycle limit both lead to DETENIDO
  always_comb begin
    estado_sig = estado_q;
    case (estado_q)
      CARGA: begin
        if (cerrando || (vaciar && !escribe)) begin
          estado_sig = ARRANQUE;
        end
      end
      ARRANQUE: begin
        if (contador_arranque == 32'(CICLOS_ARRANQUE - 1)) begin
          estado_sig = EJECUTA;
        end
      end
      EJECUTA: begin
        if (trampa || limite) begin
          estado_sig = DETENIDO;
        end
      end
      DETENIDO: estado_sig = DETENIDO;
      default:  estado_sig = CARGA;
    endcase
  end

  // Core controls are decoded from the next state so they register in step
  // with estado; the core keeps its state (no reset) once stopped
  always_comb begin
    cpu_reset_sig     = 1'b1;
    cpu_habilitar_sig = 1'b0;
    detenido_sig      = 1'b0;
    case (estado_sig)
      EJECUTA: begin
        cpu_reset_sig     = 1'b0;
        cpu_habilitar_sig = 1'b1;
      end
      DETENIDO: begin
        cpu_reset_sig = 1'b0;
        detenido_sig  = 1'b1;
      end
      default: ;
    endcase
  end

  // Hold counter for ARRANQUE, executed-cycle counter and sticky timeout.
  // The trapping instruction's own edge is still counted.
  always_ff @(posedge clk_RV) begin
    if (reset) begin
      contador_arranque <= 32'd0;
      ciclos            <= 32'd0;
      timeout           <= 1'b0;
    end else begin
      contador_arranque <= (estado_q == ARRANQUE) ? contador_arranque + 32'd1 : 32'd0;
      if ((estado_q == ARRANQUE) && (estado_sig == EJECUTA)) begin
        ciclos <= 32'd0;
      end else if ((estado_q == EJECUTA) && (ciclos != '1)) begin
        ciclos <= ciclos + 32'd1;
      end
      if ((estado_q == EJECUTA) && limite && !trampa) begin
        timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_controlador_arranque_rv32i.sv
// tb_controlador_arranque_rv32i
// Directed bench for the boot sequencer. A small memory plus fetch model
// stands in for the core: it records every instruction-memory write and
// fetches sequentially (a jal x0,0 word holds the PC). A second instance
// with a 4-word limit exercises the full-memory path.
module tb_controlador_arranque_rv32i;

  logic        clk_RV = 1'b0;
  logic        reset;
  logic [31:0] instruccion;
  logic        cpu_reset, cpu_habilitar, detenido, timeout;
  logic [1:0]  estado;
  logic [31:0] ciclos;

  logic [31:0] instr_lleno;
  logic        cpu_reset_l, cpu_habilitar_l, detenido_l, timeout_l;
  logic [1:0]  estado_l;
  logic [31:0] ciclos_l;

  int checks = 0;
  int errors = 0;

  controlador_arranque_rv32i_if #(.ADDR_W(8)) bus ();
  controlador_arranque_rv32i_if #(.ADDR_W(8)) bus_lleno ();

  controlador_arranque_rv32i #(
    .ADDR_W(8), .N_PALABRAS_MAX(256), .CICLOS_ARRANQUE(2), .MAX_CICLOS(200)
  ) dut (
    .clk_RV(clk_RV), .reset(reset), .bus(bus), .instruccion(instruccion),
    .cpu_reset(cpu_reset), .cpu_habilitar(cpu_habilitar), .estado(estado),
    .ciclos(ciclos), .detenido(detenido), .timeout(timeout)
  );

  controlador_arranque_rv32i #(
    .ADDR_W(8), .N_PALABRAS_MAX(4), .CICLOS_ARRANQUE(2), .MAX_CICLOS(200)
  ) dut_lleno (
    .clk_RV(clk_RV), .reset(reset), .bus(bus_lleno), .instruccion(instr_lleno),
    .cpu_reset(cpu_reset_l), .cpu_habilitar(cpu_habilitar_l), .estado(estado_l),
    .ciclos(ciclos_l), .detenido(detenido_l), .timeout(timeout_l)
  );

  always #5 clk_RV = ~clk_RV;

  // Memory, write log and fetch model for the main instance
  logic [31:0] mem [0:255];
  logic [31:0] wr_dato [0:1023];
  logic [7:0]  wr_dir [0:1023];
  int          n_wr = 0;
  logic [7:0]  pc = 8'd0;
  logic [7:0]  flujo [0:1023];

  assign instruccion = mem[pc];
  assign instr_lleno = 32'h0000_0013;

  always @(posedge clk_RV) begin
    if (bus.imem_we) begin
      mem[bus.imem_dir] <= bus.imem_dato;
      wr_dato[n_wr]     <= bus.imem_dato;
      wr_dir[n_wr]      <= bus.imem_dir;
      n_wr              <= n_wr + 1;
    end
  end

  always @(posedge clk_RV) begin
    if (cpu_reset) pc <= 8'd0;
    else if (cpu_habilitar && (mem[pc] != 32'h0000_006F)) pc <= pc + 8'd1;
  end

  int          n_wr_lleno = 0;
  logic [31:0] ult_dato_lleno = 32'd0;
  logic [7:0]  ult_dir_lleno = 8'd0;

  always @(posedge clk_RV) begin
    if (bus_lleno.imem_we) begin
      n_wr_lleno     <= n_wr_lleno + 1;
      ult_dato_lleno <= bus_lleno.imem_dato;
      ult_dir_lleno  <= bus_lleno.imem_dir;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    checks++;
    if (obs !== esp) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, esp);
    end
  endtask

  // One byte on the main stream for exactly one cycle, optionally with fin_carga
  task automatic applyStimulus(input logic [7:0] b, input logic fin);
    bus.byte_dato   = b;
    bus.byte_valido = 1'b1;
    bus.fin_carga   = fin;
    @(posedge clk_RV); #1;
    bus.byte_valido = 1'b0;
    bus.fin_carga   = 1'b0;
  endtask

  task automatic applyFin();
    bus.fin_carga = 1'b1;
    @(posedge clk_RV); #1;
    bus.fin_carga = 1'b0;
  endtask

  task automatic applyReset();
    reset = 1'b1;
    @(posedge clk_RV); #1;
    reset = 1'b0;
  endtask

  task automatic cargar(input int n);
    for (int i = 0; i < n; i++) applyStimulus(flujo[i], 1'b0);
  endtask

  task automatic esperarEstado(input string tag, input logic [1:0] obj, input int limite);
    int n = 0;
    while ((estado !== obj) && (n < limite)) begin
      @(posedge clk_RV); #1;
      n++;
    end
    checkOutput(tag, 32'(estado), 32'(obj));
  endtask

  task automatic ponerPalabra(input int w, input logic [31:0] p);
    flujo[4*w]   = p[7:0];
    flujo[4*w+1] = p[15:8];
    flujo[4*w+2] = p[23:16];
    flujo[4*w+3] = p[31:24];
  endtask

  initial begin
    int base;
    int n_arr;
    int acept;
    reset = 1'b1;
    bus.byte_dato = 8'd0; bus.byte_valido = 1'b0; bus.fin_carga = 1'b0;
    bus_lleno.byte_dato = 8'd0; bus_lleno.byte_valido = 1'b0; bus_lleno.fin_carga = 1'b0;
    @(posedge clk_RV); #1;

    // Reset values
    checkOutput("rst_estado", 32'(estado), 32'd0);
    checkOutput("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    checkOutput("rst_cpu_habilitar", 32'(cpu_habilitar), 32'd0);
    checkOutput("rst_byte_listo", 32'(bus.byte_listo), 32'd1);
    checkOutput("rst_imem_we", 32'(bus.imem_we), 32'd0);
    checkOutput("rst_imem_dir", 32'(bus.imem_dir), 32'd0);
    checkOutput("rst_imem_dato", bus.imem_dato, 32'd0);
    checkOutput("rst_ciclos", ciclos, 32'd0);
    checkOutput("rst_detenido", 32'(detenido), 32'd0);
    checkOutput("rst_timeout", 32'(timeout), 32'd0);
    reset = 1'b0;

    // Load addi a0,x0,10 ; ecall and run to the trap
    $display("[TB] load and ecall");
    base = n_wr;
    ponerPalabra(0, 32'h00A0_0513);
    ponerPalabra(1, 32'h0000_0073);
    cargar(8);
    applyFin();
    checkOutput("t1_n_escrituras", 32'(n_wr - base), 32'd2);
    checkOutput("t1_dir0", 32'(wr_dir[base]), 32'd0);
    checkOutput("t1_dato0", wr_dato[base], 32'h00A0_0513);
    checkOutput("t1_dir1", 32'(wr_dir[base+1]), 32'd1);
    checkOutput("t1_dato1", wr_dato[base+1], 32'h0000_0073);
    checkOutput("t1_arranque", 32'(estado), 32'd1);
    checkOutput("t1_arr_cpu_reset", 32'(cpu_reset), 32'd1);
    checkOutput("t1_arr_byte_listo", 32'(bus.byte_listo), 32'd0);
    n_arr = 0;
    while ((estado == 2'b01) && (n_arr < 10)) begin
      @(posedge clk_RV); #1;
      n_arr++;
    end
    checkOutput("t1_ciclos_arranque", 32'(n_arr), 32'd2);
    checkOutput("t1_ejecuta", 32'(estado), 32'd2);
    checkOutput("t1_ej_cpu_reset", 32'(cpu_reset), 32'd0);
    checkOutput("t1_ej_habilitar", 32'(cpu_habilitar), 32'd1);
    esperarEstado("t1_detenido", 2'b11, 20);
    checkOutput("t1_ciclos", ciclos, 32'd2);
    checkOutput("t1_flag_detenido", 32'(detenido), 32'd1);
    checkOutput("t1_timeout", 32'(timeout), 32'd0);
    checkOutput("t1_det_habilitar", 32'(cpu_habilitar), 32'd0);
    checkOutput("t1_det_cpu_reset", 32'(cpu_reset), 32'd0);
    base = n_wr;
    applyStimulus(8'hFF, 1'b1);
    repeat (2) @(posedge clk_RV);
    #1;
    checkOutput("t1_det_ignora", 32'(estado), 32'd3);
    checkOutput("t1_det_sin_escritura", 32'(n_wr - base), 32'd0);
    checkOutput("t1_det_ciclos_fijos", ciclos, 32'd2);

    // Partial word zero-padded on flush
    $display("[TB] partial word");
    applyReset();
    base = n_wr;
    flujo[0] = 8'h93; flujo[1] = 8'h00; flujo[2] = 8'h10; flujo[3] = 8'h00;
    flujo[4] = 8'hAA; flujo[5] = 8'hBB;
    cargar(6);
    applyFin();
    checkOutput("t2_we_relleno", 32'(bus.imem_we), 32'd1);
    checkOutput("t2_cierre_estado", 32'(estado), 32'd0);
    checkOutput("t2_cierre_listo", 32'(bus.byte_listo), 32'd0);
    @(posedge clk_RV); #1;
    checkOutput("t2_arranque", 32'(estado), 32'd1);
    checkOutput("t2_n_escrituras", 32'(n_wr - base), 32'd2);
    checkOutput("t2_dato0", wr_dato[base], 32'h0010_0093);
    checkOutput("t2_dir1", 32'(wr_dir[base+1]), 32'd1);
    checkOutput("t2_dato1", wr_dato[base+1], 32'h0000_BBAA);

    // Self-loop runs into the cycle limit
    $display("[TB] timeout");
    applyReset();
    ponerPalabra(0, 32'h0000_006F);
    cargar(4);
    applyFin();
    esperarEstado("t3_detenido", 2'b11, 300);
    checkOutput("t3_timeout", 32'(timeout), 32'd1);
    checkOutput("t3_ciclos", ciclos, 32'd200);
    checkOutput("t3_habilitar", 32'(cpu_habilitar), 32'd0);
    checkOutput("t3_flag_detenido", 32'(detenido), 32'd1);

    // Last byte together with fin_carga: a single write, no padded extra
    $display("[TB] byte with fin_carga");
    applyReset();
    base = n_wr;
    applyStimulus(8'h73, 1'b0);
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h10, 1'b0);
    applyStimulus(8'h00, 1'b1);
    checkOutput("t5_we", 32'(bus.imem_we), 32'd1);
    checkOutput("t5_cierre_estado", 32'(estado), 32'd0);
    @(posedge clk_RV); #1;
    checkOutput("t5_arranque", 32'(estado), 32'd1);
    checkOutput("t5_we_bajo", 32'(bus.imem_we), 32'd0);
    checkOutput("t5_n_escrituras", 32'(n_wr - base), 32'd1);
    checkOutput("t5_dato", wr_dato[base], 32'h0010_0073);
    esperarEstado("t5_detenido", 2'b11, 20);
    checkOutput("t5_ciclos", ciclos, 32'd1);

    // EBREAK fetched on the cycle the limit is reached: trap wins
    $display("[TB] ebreak at limit");
    applyReset();
    for (int w = 0; w < 199; w++) ponerPalabra(w, 32'h0000_0013);
    ponerPalabra(199, 32'h0010_0073);
    cargar(800);
    applyFin();
    esperarEstado("t6_detenido", 2'b11, 400);
    checkOutput("t6_timeout", 32'(timeout), 32'd0);
    checkOutput("t6_ciclos", ciclos, 32'd200);

    // Reset in the middle of execution
    $display("[TB] reset during execution");
    applyReset();
    ponerPalabra(0, 32'h0000_006F);
    cargar(4);
    applyFin();
    esperarEstado("t7_ejecuta", 2'b10, 20);
    repeat (5) @(posedge clk_RV);
    #1;
    applyReset();
    checkOutput("t7_estado", 32'(estado), 32'd0);
    checkOutput("t7_cpu_reset", 32'(cpu_reset), 32'd1);
    checkOutput("t7_habilitar", 32'(cpu_habilitar), 32'd0);
    checkOutput("t7_ciclos", ciclos, 32'd0);
    checkOutput("t7_detenido", 32'(detenido), 32'd0);
    checkOutput("t7_byte_listo", 32'(bus.byte_listo), 32'd1);

    // Full memory on the 4-word instance: 20 bytes offered, 16 accepted
    $display("[TB] full memory");
    applyReset();
    base = n_wr_lleno;
    acept = 0;
    for (int i = 0; i < 20; i++) begin
      bus_lleno.byte_dato   = 8'(i + 1);
      bus_lleno.byte_valido = 1'b1;
      if (bus_lleno.byte_listo) acept++;
      @(posedge clk_RV); #1;
      if (i == 15) checkOutput("t4_listo_tras_16", 32'(bus_lleno.byte_listo), 32'd0);
    end
    bus_lleno.byte_valido = 1'b0;
    checkOutput("t4_aceptados", 32'(acept), 32'd16);
    checkOutput("t4_n_escrituras", 32'(n_wr_lleno - base), 32'd4);
    checkOutput("t4_ult_dir", 32'(ult_dir_lleno), 32'd3);
    checkOutput("t4_ult_dato", ult_dato_lleno, 32'h100F_0E0D);
    bus_lleno.fin_carga = 1'b1;
    @(posedge clk_RV); #1;
    bus_lleno.fin_carga = 1'b0;
    checkOutput("t4_arranque", 32'(estado_l), 32'd1);
    checkOutput("t4_sin_escritura_extra", 32'(n_wr_lleno - base), 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation did not finish");
  end

endmodule

// File: doc/controlador_arranque_rv32i.md
Name: controlador_arranque_rv32i

Overview:
- Boot-and-run sequencer for the single-cycle rv32i core.
- Holds the core in reset while a little-endian byte stream is packed into 32-bit words and written to instruction memory.
- Releases the core, gates its clock enable, and counts executed cycles.
- Stops the core on ECALL/EBREAK or a cycle timeout. Replaces free-running, time-boxed simulation with deterministic program termination.

Parameters:
- ADDR_W, 8, instruction-memory word-address width.
- N_PALABRAS_MAX, 256, words writable; must be ≤ 2**ADDR_W.
- CICLOS_ARRANQUE, 2, cycles core reset is held after load completes; ≥ 1.
- MAX_CICLOS, 200, execution cycle limit before timeout.

Ports:
- clk_RV  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- byte_dato  in  8  program byte.
- byte_valido  in  1  byte_dato valid.
- byte_listo  out  1  byte accepted on an edge where byte_valido && byte_listo.
- fin_carga  in  1  single-cycle pulse: stream complete.
- imem_we  out  1  instruction-memory write strobe, one cycle per word.
- imem_dir  out  ADDR_W  word address.
- imem_dato  out  32  word to write.
- cpu_reset  out  1  core reset, active-high.
- cpu_habilitar  out  1  core clock enable.
- instruccion  in  32  instruction currently fetched by the core.
- estado  out  2  00 CARGA, 01 ARRANQUE, 10 EJECUTA, 11 DETENIDO.
- ciclos  out  32  executed-cycle count.
- detenido  out  1  high in DETENIDO.
- timeout  out  1  sticky: stop caused by MAX_CICLOS.

Behaviour:
- Single clock domain. Reset is synchronous and active-high; clock is clk_RV, reset is reset.
- Reset values:
  - estado = CARGA, cpu_reset = 1, cpu_habilitar = 0, byte_listo = 1, imem_we = 0.
  - imem_dir = 0, imem_dato = 0, ciclos = 0, detenido = 0, timeout = 0.
  - Internal byte counter = 0, word index = 0.
- Reset mid-operation returns to CARGA from any state. Instruction-memory contents are untouched (the memory is external).
- CARGA, byte packing:
  - Accepted byte k (0..3) goes into bits [8k+7:8k], little-endian.
  - On acceptance of byte 3, the next edge registers imem_we = 1, imem_dir = word index, imem_dato = packed word; word index then increments.
  - imem_we is high exactly one cycle per word. Back-to-back bytes are accepted at full rate with no bubble.
- Full condition: when word index = N_PALABRAS_MAX, byte_listo = 0. Further bytes are refused and no write occurs.
- fin_carga handling:
  - A byte accepted in the same cycle as fin_carga is included.
  - If a partial word remains (1–3 bytes), it is zero-padded in the upper bytes and written, if room remains, in the next cycle.
  - Otherwise no extra write occurs.
  - The FSM enters ARRANQUE on the cycle after the last write, or on the next edge if there is no pending write.
- fin_carga with zero words loaded is legal: the core runs whatever memory contains.
- ARRANQUE:
  - cpu_reset = 1, cpu_habilitar = 0, byte_listo = 0, held for exactly CICLOS_ARRANQUE cycles.
  - Then EJECUTA. ciclos is cleared on entry.
- EJECUTA:
  - cpu_reset = 0, cpu_habilitar = 1.
  - ciclos increments every cycle in EJECUTA.
  - If instruccion = 32'h00000073 (ECALL) or 32'h00100073 (EBREAK), the next state is DETENIDO. The trapping instruction's own edge is still enabled and counted, so ciclos includes it.
  - If ciclos reaches MAX_CICLOS−1 while incrementing, the next state is DETENIDO with timeout = 1 and ciclos = MAX_CICLOS.
  - Trap and timeout on the same cycle: trap wins, timeout = 0.
- DETENIDO:
  - cpu_habilitar = 0, cpu_reset = 0 (architectural state preserved for inspection).
  - detenido = 1; ciclos frozen.
  - Sticky until reset. byte_valido and fin_carga are ignored.
- ciclos is 32-bit and saturates, never wraps. Saturation is unreachable with MAX_CICLOS < 2**32.
- All outputs are registered; no combinational input-to-output paths except byte_listo, which is decoded from state plus the full flag.

Decomposition:
- Shared package rv32i_pkg holds:
  - State encoding constants: CARGA, ARRANQUE, EJECUTA, DETENIDO.
  - OPC_ECALL = 32'h00000073 and OPC_EBREAK = 32'h00100073.
- One sub-module, empaquetador_bytes: byte-to-word packing with counter, padding on flush, and write strobe, with a valid/ready input and a word-valid output.
- The FSM, cycle counter and trap detection stay in the top module.

Test Plan:
- Reset and load: stream 8 bytes 13,05,A0,00,73,00,00,00, then fin_carga → writes (dir 0, 00A00513) and (dir 1, 00000073); cpu_reset held 2 cycles; EJECUTA; DETENIDO with ciclos = 2.
- Partial word: 6 bytes 93,00,10,00,AA,BB, then fin_carga → second write is dir 1, 0000BBAA; then ARRANQUE.
- Timeout: load 4 bytes 6F,00,00,00 (jal x0,0 self-loop) with MAX_CICLOS = 200 → DETENIDO, timeout = 1, ciclos = 200, cpu_habilitar = 0.
- Full memory: N_PALABRAS_MAX = 4, offer 20 bytes → exactly 4 imem_we pulses, byte_listo low after the 16th byte accepted; fin_carga then starts ARRANQUE.
- Simultaneity: byte_valido with fin_carga on the 4th byte → word written once, no extra padded write. Separately, EBREAK fetched on the cycle ciclos hits the limit → timeout = 0.
- Reset mid-EJECUTA: assert reset for 1 cycle → estado = CARGA, cpu_reset = 1, ciclos = 0, detenido = 0, byte_listo = 1.
